// File: rtl/pid_multi_pkg.sv
// Shared constants, gain record and saturating arithmetic helpers for the
// multi-channel PID pipeline.
package pid_multi_pkg;

   localparam logic [2:0] CFG_KP    = 3'd0;
   localparam logic [2:0] CFG_KI    = 3'd1;
   localparam logic [2:0] CFG_KD    = 3'd2;
   localparam logic [2:0] CFG_SHIFT = 3'd3;
   localparam logic [2:0] CFG_ILIM  = 3'd4;
   localparam logic [2:0] CFG_CLEAR = 3'd5;

   typedef logic signed [63:0] wide_t;

   // Gains are held sign-extended to 16 bits so the record is independent of KW.
   typedef struct packed {
      logic signed [15:0] kp;
      logic signed [15:0] ki;
      logic signed [15:0] kd;
      logic [8:0]         sh;       // {sd, si, sp}
      logic [15:0]        int_lim;
   } gain_t;

   function automatic wide_t sat(input wide_t x, input int w);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic wide_t clamp(input wide_t x, input wide_t lim);
      if (x > lim) return lim;
      if (x < -lim) return -lim;
      return x;
   endfunction

   function automatic wide_t ashr_sat(input wide_t x, input logic [2:0] sh, input int w);
      return sat(x >>> sh, w);
   endfunction

endpackage

// File: rtl/pid_multi_state_rf.sv
// Per-channel err_prev / int_acc storage: async read, one write port and a
// clear port that overrides a same-cycle write.
module pid_state_rf #(
   parameter int W   = 13,
   parameter int NCH = 4,
   parameter int CHW = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHW-1:0]      rd_ch,
   output logic signed [W-1:0] rd_err,
   output logic signed [W-1:0] rd_int,
   input  logic                we,
   input  logic [CHW-1:0]      wr_ch,
   input  logic signed [W-1:0] wr_err,
   input  logic signed [W-1:0] wr_int,
   input  logic                clr,
   input  logic [CHW-1:0]      clr_ch
);
   logic signed [W-1:0] err_mem [NCH];
   logic signed [W-1:0] int_mem [NCH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) begin
            err_mem[k] <= '0;
            int_mem[k] <= '0;
         end
      end else begin
         if (we) begin
            err_mem[wr_ch] <= wr_err;
            int_mem[wr_ch] <= wr_int;
         end
         // Later non-blocking assignment gives the clear priority.
         if (clr) begin
            err_mem[clr_ch] <= '0;
            int_mem[clr_ch] <= '0;
         end
      end
   end

   assign rd_err = err_mem[rd_ch];
   assign rd_int = int_mem[rd_ch];
endmodule

// File: rtl/pid_multi.sv
// Six-stage time-multiplexed PID controller with per-channel gains and state,
// saturating arithmetic and same-channel hazard stalls on the input handshake.
module pid_multi
   import pid_multi_pkg::*;
#(
   parameter int W   = 13,
   parameter int KW  = 13,
   parameter int NCH = 4,
   localparam int CHW = $clog2(NCH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CHW-1:0]      in_ch,
   input  logic signed [W-1:0] cmd,
   input  logic signed [W-1:0] meas,
   input  logic                cfg_we,
   input  logic [CHW-1:0]      cfg_ch,
   input  logic [2:0]          cfg_addr,
   input  logic [15:0]         cfg_wdata,
   output logic                out_valid,
   output logic [CHW-1:0]      out_ch,
   output logic [W-2:0]        pwm,
   output logic [1:0]          drive_code,
   output logic signed [W-1:0] err,
   output logic signed [W-1:0] int_err
);
   localparam int PW = W + KW;
   localparam logic signed [W-1:0] U_MIN = {1'b1, {(W-1){1'b0}}};

   gain_t gains_reg [NCH];
   logic  ready_en_reg;
   logic  accept;
   logic  unused_cfg;

   logic signed [W-1:0] rd_err, rd_int;

   logic s0_v, s1_v, s2_v, s3_v, s4_v;
   logic [CHW-1:0] s0_ch, s1_ch, s2_ch, s3_ch, s4_ch;
   logic signed [W-1:0] s0_cmd, s0_meas, s0_ep, s0_ia, s1_e, s1_ep, s1_ia;
   gain_t s0_g, s1_g;
   logic signed [W-1:0] s2_e, s2_i, s2_d, s3_e, s3_i, s4_e, s4_i;
   logic signed [15:0] s2_kp, s2_ki, s2_kd;
   logic [8:0] s2_sh, s3_sh;
   logic signed [PW-1:0] s3_p, s3_ip, s3_dp;
   logic signed [W-1:0] s4_p, s4_it, s4_d;
   logic signed [W-1:0] u_sum;

   assign unused_cfg = ^cfg_wdata;

   assign in_ready = ready_en_reg
                     && !(s0_v && s0_ch == in_ch)
                     && !(s1_v && s1_ch == in_ch)
                     && !(s2_v && s2_ch == in_ch);
   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_reg <= 1'b0;
         for (int k = 0; k < NCH; k++) gains_reg[k] <= '0;
      end else begin
         ready_en_reg <= 1'b1;
         for (int k = 0; k < NCH; k++) begin
            if (cfg_we && cfg_ch == CHW'(k)) begin
               case (cfg_addr)
                  CFG_KP:    gains_reg[k].kp      <= 16'(signed'(cfg_wdata[KW-1:0]));
                  CFG_KI:    gains_reg[k].ki      <= 16'(signed'(cfg_wdata[KW-1:0]));
                  CFG_KD:    gains_reg[k].kd      <= 16'(signed'(cfg_wdata[KW-1:0]));
                  CFG_SHIFT: gains_reg[k].sh      <= cfg_wdata[8:0];
                  CFG_ILIM:  gains_reg[k].int_lim <= 16'(cfg_wdata[W-2:0]);
                  default: ;
               endcase
            end
         end
      end
   end

   pid_state_rf #(.W(W), .NCH(NCH), .CHW(CHW)) u_state (
      .clk    (clk),
      .rst_n  (rst_n),
      .rd_ch  (in_ch),
      .rd_err (rd_err),
      .rd_int (rd_int),
      .we     (s2_v),
      .wr_ch  (s2_ch),
      .wr_err (s2_e),
      .wr_int (s2_i),
      .clr    (cfg_we && cfg_addr == CFG_CLEAR),
      .clr_ch (cfg_ch)
   );

   assign u_sum = W'(sat(sat(wide_t'(s4_p) + wide_t'(s4_d), W) + wide_t'(s4_it), W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {s0_v, s1_v, s2_v, s3_v, s4_v} <= '0;
         {s0_ch, s1_ch, s2_ch, s3_ch, s4_ch} <= '0;
         {s0_cmd, s0_meas, s0_ep, s0_ia, s1_e, s1_ep, s1_ia} <= '0;
         s0_g <= '0;
         s1_g <= '0;
         {s2_e, s2_i, s2_d, s3_e, s3_i, s4_e, s4_i} <= '0;
         {s2_kp, s2_ki, s2_kd, s2_sh, s3_sh} <= '0;
         {s3_p, s3_ip, s3_dp, s4_p, s4_it, s4_d} <= '0;
         out_valid  <= 1'b0;
         out_ch     <= '0;
         pwm        <= '0;
         drive_code <= 2'b00;
         err        <= '0;
         int_err    <= '0;
      end else begin
         s0_v <= accept;
         if (accept) begin
            s0_ch   <= in_ch;
            s0_cmd  <= cmd;
            s0_meas <= meas;
            s0_g    <= gains_reg[in_ch];
            s0_ep   <= rd_err;
            s0_ia   <= rd_int;
         end

         s1_v  <= s0_v;
         s1_ch <= s0_ch;
         s1_g  <= s0_g;
         s1_ep <= s0_ep;
         s1_ia <= s0_ia;
         s1_e  <= W'(sat(wide_t'(s0_cmd) - wide_t'(s0_meas), W));

         s2_v  <= s1_v;
         s2_ch <= s1_ch;
         s2_e  <= s1_e;
         s2_i  <= W'(clamp(wide_t'(s1_ia) + wide_t'(s1_e), wide_t'(s1_g.int_lim)));
         s2_d  <= W'(sat(wide_t'(s1_e) - wide_t'(s1_ep), W));
         s2_kp <= s1_g.kp;
         s2_ki <= s1_g.ki;
         s2_kd <= s1_g.kd;
         s2_sh <= s1_g.sh;

         s3_v  <= s2_v;
         s3_ch <= s2_ch;
         s3_e  <= s2_e;
         s3_i  <= s2_i;
         s3_sh <= s2_sh;
         s3_p  <= PW'(wide_t'(s2_kp) * wide_t'(s2_e));
         s3_ip <= PW'(wide_t'(s2_ki) * wide_t'(s2_i));
         s3_dp <= PW'(wide_t'(s2_kd) * wide_t'(s2_d));

         s4_v  <= s3_v;
         s4_ch <= s3_ch;
         s4_e  <= s3_e;
         s4_i  <= s3_i;
         s4_p  <= W'(ashr_sat(wide_t'(s3_p),  s3_sh[2:0], W));
         s4_it <= W'(ashr_sat(wide_t'(s3_ip), s3_sh[5:3], W));
         s4_d  <= W'(ashr_sat(wide_t'(s3_dp), s3_sh[8:6], W));

         out_valid <= s4_v;
         if (s4_v) begin
            out_ch     <= s4_ch;
            err        <= s4_e;
            int_err    <= s4_i;
            drive_code <= {~u_sum[W-1], u_sum[W-1]};
            // The most negative value has no positive twin, so it pins to full scale.
            if (u_sum == U_MIN) pwm <= '1;
            else if (u_sum[W-1]) pwm <= (W-1)'(-u_sum);
            else pwm <= (W-1)'(u_sum);
         end
      end
   end
endmodule

// File: doc/pid_multi.md
# pid_multi

Multi-channel, parametrised PID controller pipeline for the motor-drive path. Time-multiplexes up to NCH motor channels through one six-stage datapath. Holds per-channel previous error and integrator state internally, so callers no longer carry them. Adds saturating arithmetic, integrator clamping, shift-based gain denominators and a valid/ready input handshake with same-channel hazard stalls.

## Interface
- W, 13: signed width of setpoint, measurement, error and integrator
- KW, 13: signed gain numerator width
- NCH, 4: channel count (≥2); CHW = $clog2(NCH)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample offered
- in_ready  out  1  sample accepted when in_valid && in_ready
- in_ch  in  CHW  channel of sample
- cmd  in  W  signed setpoint (position or velocity)
- meas  in  W  signed measurement
- cfg_we  in  1  config write strobe
- cfg_ch  in  CHW  config target channel
- cfg_addr  in  3  0 Kp, 1 Ki, 2 Kd, 3 shifts {sd[2:0],si[2:0],sp[2:0]}, 4 int_lim, 5 clear state
- cfg_wdata  in  16  config data, low bits used
- out_valid  out  1  result valid, one-cycle pulse per sample
- out_ch  out  CHW  channel of result
- pwm  out  W-1  saturated magnitude of PID output
- drive_code  out  2  {!neg, neg}
- err  out  W  error of this sample
- int_err  out  W  integrator after update

## Operation
- Per channel: Kp/Ki/Kd (KW signed), sp/si/sd (0–7), int_lim (W-1 unsigned, positive), err_prev, int_acc.
- e = sat_W(cmd − meas).
- i = clamp(int_acc + e, −int_lim, +int_lim), computed at full precision before clamping.
- d = sat_W(e − err_prev).
- Each term: product (W+KW bits) arithmetic right shift by its shift value, then sat_W.
- u = sat_W(sat_W(P + D) + I).
- pwm = |u| saturated to 2^(W-1)−1: u = −2^(W-1) gives all-ones.
- neg = u[W-1].
- Writeback at end of S2: err_prev ← e, int_acc ← i.
- cfg_addr 5: zeroes err_prev and int_acc. If it coincides with a writeback to the same channel, the clear wins.
- Config writes take effect for samples accepted after the write edge. Gains are captured at S0, so in-flight samples use the old values.
- Unused cfg_addr values (6, 7): ignored.
- Hazard: in_ready = 0 when in_ch equals the channel of any valid sample in S0, S1 or S2. Otherwise in_ready = 1. No other backpressure; the output cannot be stalled.
- Reset values:
  - all outputs 0, including drive_code 2'b00 and in_ready 0 during reset
  - all gains, shifts, int_lim and state 0
  - in_ready 1 from the first edge after deassertion
- Reset mid-operation flushes every stage; no out_valid is produced for flushed samples.

## Timing
- Stages:
  - S0: capture inputs, read channel state and gains
  - S1: error
  - S2: integrate, derivative, writeback
  - S3: multiply
  - S4: shift and saturate
  - S5: sum and output register
- Latency: a sample accepted at edge t gives out_valid high in the cycle after edge t+5 (6 edges).
- Throughput: one sample per cycle when consecutive samples use distinct channels within any 4-sample window.
- Same channel back-to-back: 3 stall cycles, so the second sample is accepted 4 edges after the first.

## Structure
- pid_multi_pkg holds:
  - cfg_addr constants
  - sat(), clamp() and ashr_sat() functions
  - the per-channel gain record typedef
- One sub-module, pid_state_rf: NCH-entry register file for err_prev/int_acc with one async read, one write port and a clear port (clear priority). Gains stay in pid_multi.

## Test plan
- Reset: assert rst_n=0 mid-stream → all outputs 0 immediately; in_ready 1 one edge after release; no stale out_valid.
- Proportional: ch0 Kp=1, shifts 0, Ki=Kd=0, cmd=100, meas=40 → 6 edges later pwm=60, drive_code=2'b10, err=60, out_ch=0.
- Saturation: Kp=2, cmd=4095, meas=−4096 → err=4095, pwm=4095. Then cmd=−4096, meas=4095 → err=−4096, pwm=4095, drive_code=2'b01.
- Integrator clamp: ch2 Ki=1, int_lim=100, Kp=Kd=0, two samples err=60 → int_err 60 then 100, pwm 60 then 100. Cfg clear → next sample int_err=60.
- Derivative and shift: ch3 Kd=8, sd=2, errors 10 then 30 → D outputs 20 then 40.
- Hazard: ch1 offered on 2 consecutive cycles → in_ready low 3 cycles; results in order. Round-robin ch0–3 for 16 cycles → no stalls, 16 consecutive out_valid.
